// File: rtl/serializer_pkg.sv
// Shared UART transmit-path definitions: frame width and the bit-counter width
// that the TX FSM, parity calculator and output mux reuse alongside the serializer.
package serializer_pkg;

    localparam int SER_DATA_WIDTH = 8;
    localparam int SER_CNT_WIDTH  = $clog2(SER_DATA_WIDTH);

    typedef logic [SER_DATA_WIDTH-1:0] ser_word_t;
    typedef logic [SER_CNT_WIDTH-1:0]  ser_count_t;

endpackage : serializer_pkg

// File: rtl/serializer_if.sv
// Parallel-load / serial-out bundle between the UART TX FSM side (master)
// and the serializer (slave).
interface serializer_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  ser_en;
    logic                  ser_done;
    logic                  ser_data;

    modport master (
        output P_DATA,
        output Data_Valid,
        output ser_en,
        input  ser_done,
        input  ser_data
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  ser_en,
        output ser_done,
        output ser_data
    );

endinterface : serializer_if

// File: rtl/serializer.sv
// UART TX parallel-to-serial converter: loads a word while idle and shifts it
// out LSB-first while ser_en is high, flagging the last data bit with ser_done.
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = SER_DATA_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    serializer_if.slave   bus
);

    localparam int                   CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT  = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]  cnt;

    // Shifting has priority over loading so a frame in flight is never overwritten;
    // dropping ser_en restarts the count but keeps the unsent bits in shreg.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bus.ser_en) begin
            shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            cnt   <= (cnt == LAST_BIT) ? '0 : cnt + CNT_WIDTH'(1);
        end else begin
            cnt <= '0;
            if (bus.Data_Valid) begin
                shreg <= bus.P_DATA;
            end
        end
    end

    assign bus.ser_data = shreg[0];
    assign bus.ser_done = bus.ser_en & (cnt == LAST_BIT);

endmodule : serializer

// File: tb/tb_serializer.sv
// Directed scoreboard bench for the UART serializer: the stimulus side queues
// the hand-computed serial stream, a negedge monitor checks every enabled cycle.
module tb_serializer;
    import serializer_pkg::*;

    typedef struct {
        logic  data;
        logic  done;
        string tag;
        int    k;
    } exp_t;

    logic CLK;
    logic RST;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expq[$];

    serializer_if #(.DATA_WIDTH(SER_DATA_WIDTH)) bus ();

    serializer #(.DATA_WIDTH(SER_DATA_WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every cycle with ser_en high out of reset must match the next queued bit.
    always @(negedge CLK) begin
        if (RST && bus.ser_en) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_bit: got data=%0b done=%0b, required no enabled cycle",
                         bus.ser_data, bus.ser_done);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (bus.ser_data !== e.data || bus.ser_done !== e.done) begin
                    miscompares++;
                    $display("[TB] FAIL %s[%0d]: got data=%0b done=%0b, required data=%0b done=%0b",
                             e.tag, e.k, bus.ser_data, bus.ser_done, e.data, e.done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_data, input logic exp_done);
        vectors++;
        if (bus.ser_data !== exp_data || bus.ser_done !== exp_done) begin
            miscompares++;
            $display("[TB] FAIL %s: got data=%0b done=%0b, required data=%0b done=%0b",
                     tag, bus.ser_data, bus.ser_done, exp_data, exp_done);
        end
    endtask

    // Optional load, then n enabled cycles; bit k of exp_bits/exp_done is cycle k.
    task automatic applyStimulus(input string tag, input bit do_load, input logic [7:0] word,
                                 input int n, input logic [15:0] exp_bits,
                                 input logic [15:0] exp_done, input int inject_k,
                                 input logic [7:0] inject_val, input bit hold_en);
        if (do_load) begin
            bus.ser_en     = 1'b0;
            bus.P_DATA     = word;
            bus.Data_Valid = 1'b1;
            tick();
            bus.Data_Valid = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            bus.ser_en = 1'b1;
            if (k == inject_k) begin
                bus.Data_Valid = 1'b1;
                bus.P_DATA     = inject_val;
            end else begin
                bus.Data_Valid = 1'b0;
            end
            expq.push_back('{data: exp_bits[k], done: exp_done[k], tag: tag, k: k});
            tick();
        end
        bus.Data_Valid = 1'b0;
        if (!hold_en) begin
            bus.ser_en = 1'b0;
            tick();
        end
    endtask

    initial begin
        RST            = 1'b1;
        bus.P_DATA     = 8'($urandom);
        bus.Data_Valid = 1'($urandom_range(0, 1));
        bus.ser_en     = 1'b0;

        #2 RST = 1'b0;
        #1 checkOutput("rst_async", 1'b0, 1'b0);
        repeat (2) begin
            bus.P_DATA     = 8'($urandom);
            bus.Data_Valid = 1'($urandom_range(0, 1));
            bus.ser_en     = 1'($urandom_range(0, 1));
            tick();
            checkOutput("rst_hold", 1'b0, 1'b0);
        end
        bus.ser_en     = 1'b0;
        bus.Data_Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        tick();

        applyStimulus("basic",   1'b1, 8'b11101101, 8,  16'h00ED, 16'h0080, -1, 8'h00, 1'b0);
        applyStimulus("over_en", 1'b1, 8'b11101101, 10, 16'h00ED, 16'h0080, -1, 8'h00, 1'b0);
        applyStimulus("blocked", 1'b1, 8'hA5,       8,  16'h00A5, 16'h0080,  2, 8'hFF, 1'b0);
        applyStimulus("b2b_01",  1'b1, 8'h01,       8,  16'h0001, 16'h0080, -1, 8'h00, 1'b0);
        applyStimulus("b2b_80",  1'b1, 8'h80,       8,  16'h0080, 16'h0080, -1, 8'h00, 1'b0);

        // Pausing mid-frame restarts the count on the remaining bits (0xA5 >> 3 = 0x14).
        applyStimulus("pause_a", 1'b1, 8'hA5,       3,  16'h0005, 16'h0000, -1, 8'h00, 1'b0);
        applyStimulus("pause_b", 1'b0, 8'h00,       8,  16'h0014, 16'h0080, -1, 8'h00, 1'b0);

        applyStimulus("pre_rst", 1'b1, 8'b11101101, 3,  16'h0005, 16'h0000, -1, 8'h00, 1'b1);
        RST = 1'b0;
        #1 checkOutput("rst_mid", 1'b0, 1'b0);
        bus.ser_en = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        applyStimulus("post_rst", 1'b1, 8'h3C,      8,  16'h003C, 16'h0080, -1, 8'h00, 1'b0);

        repeat (2) tick();
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d unchecked bits, required 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serializer

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter for the UART transmit path.
- Captures an 8-bit parallel word when Data_Valid is asserted.
- Shifts the word out LSB-first, one bit per clock, while the TX FSM holds ser_en high.
- Flags the final data bit with ser_done so the FSM can advance to the parity/stop state.

Parameters:
- DATA_WIDTH, 8, width of P_DATA and number of bits serialized per frame (must be >= 2).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data word to transmit.
- Data_Valid  input  1  P_DATA is valid; load request.
- ser_en  input  1  serialization enable from the TX FSM.
- ser_done  output  1  high while the last data bit is being presented.
- ser_data  output  1  current serial bit.

Behaviour:
- Internal state: shift register shreg[DATA_WIDTH-1:0] and bit counter cnt[$clog2(DATA_WIDTH)-1:0].
- Reset (RST=0, asynchronous): shreg=0, cnt=0, so ser_data=0 and ser_done=0. Reset mid-frame aborts the frame immediately.
- Load: at a rising edge with Data_Valid=1 and ser_en=0, shreg<=P_DATA and cnt<=0.
  - Data_Valid while ser_en=1 is ignored; a frame in progress is never corrupted.
- ser_data = shreg[0] (combinational from the register).
  - The first bit (P_DATA[0]) is therefore on ser_data in the same cycle ser_en first rises.
  - There is no extra latency cycle.
- Shift: at each rising edge with ser_en=1:
  - shreg<=shreg>>1, with 0 shifted into the MSB.
  - cnt<=cnt+1, wrapping to 0 after DATA_WIDTH-1.
- ser_done = ser_en & (cnt==DATA_WIDTH-1), combinational.
  - Asserted for exactly one cycle: the cycle in which bit DATA_WIDTH-1 is on ser_data.
- Frame cycle k (k=0..DATA_WIDTH-1 counted from the first ser_en=1 cycle): ser_data = P_DATA[k].
- ser_en held beyond DATA_WIDTH cycles:
  - ser_data=0, since the register has been emptied.
  - cnt keeps wrapping, so ser_done re-pulses every DATA_WIDTH cycles. The FSM is responsible for dropping ser_en.
- ser_en=0 with no load: cnt<=0 and shreg holds. Deasserting ser_en mid-frame therefore restarts the count; the remaining bits stay in shreg.
- Simultaneous Data_Valid=1 and ser_en=1: shift wins, the load is ignored.
- No other outputs; no FSM inside the block (two-state behaviour is implied by ser_en).

Decomposition:
- Shared UART package: DATA_WIDTH default (8) and a localparam for the counter width, $clog2(DATA_WIDTH). The TX FSM, parity calculator and mux reuse these.
- No sub-module required. The bit counter may be split out as serializer_bit_counter if reused by the parity block; otherwise keep it inline.

Test Plan:
- Reset: assert RST=0 with random inputs -> ser_data=0 and ser_done=0 immediately (asynchronously, before the next clock edge).
- Basic frame:
  - Stimulus: P_DATA=8'b11101101; Data_Valid=1 for one cycle, then ser_en=1 for 8 cycles.
  - Required ser_data sequence: 1,0,1,1,0,1,1,1.
  - Required ser_done: high only in the 8th cycle.
- Over-enable: same load, ser_en held 10 cycles -> cycles 9-10 show ser_data=0 and ser_done=0.
- Load blocked during shift: with 8'hA5 loaded, pulse Data_Valid with P_DATA=8'hFF in cycle 3 of the frame -> output is still 1,0,1,0,0,1,0,1.
- Back-to-back frames: load 8'h01, shift 8, drop ser_en, load 8'h80, shift 8 -> sequences 10000000 then 00000001, with ser_done high at cycle 8 of each frame.
- Reset mid-frame: RST=0 at cycle 4 of the frame -> outputs 0 at once. A subsequent load of 8'h3C and shift yields 0,0,1,1,1,1,0,0.
